// File: rtl/prbs_pkg.sv
// Shared types for the PRBS word sequencer: controller states and default
// maximal-length Fibonacci tap masks (bit i set = value[i] feeds the XOR).
package prbs_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GENERATE = 2'd1,
      OUTPUT   = 2'd2,
      FINISH   = 2'd3
   } state_t;

   localparam logic [3:0]  TAPS_4  = 4'h3;
   localparam logic [6:0]  TAPS_7  = 7'h03;
   localparam logic [7:0]  TAPS_8  = 8'h1D;
   localparam logic [15:0] TAPS_16 = 16'h100B;
   localparam logic [31:0] TAPS_32 = 32'hC000_0401;

   // Masks are the reciprocals of the usual Galois tap tables, because the
   // feedback enters at the MSB while the register shifts towards bit 0.
   function automatic logic [31:0] default_taps(input int width);
      logic [31:0] taps;
      case (width)
         4:       taps = 32'(TAPS_4);
         7:       taps = 32'(TAPS_7);
         8:       taps = 32'(TAPS_8);
         16:      taps = 32'(TAPS_16);
         32:      taps = TAPS_32;
         default: taps = 32'(TAPS_8);
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/prbs_word_sequencer_if.sv
// Control and word-stream bundle of the PRBS word sequencer; master is the
// sequencer, slave is the controlling/consuming side.
interface prbs_word_sequencer_if #(
   parameter int LFSR_WIDTH  = 8,
   parameter int WORD_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
);
   logic                   start;
   logic                   abort;
   logic [LFSR_WIDTH-1:0]  seed;
   logic [COUNT_WIDTH-1:0] word_count;
   logic                   out_valid;
   logic                   out_ready;
   logic [WORD_WIDTH-1:0]  out_data;
   logic                   busy;
   logic                   done;

   modport master (
      input  start, abort, seed, word_count, out_ready,
      output out_valid, out_data, busy, done
   );

   modport slave (
      output start, abort, seed, word_count, out_ready,
      input  out_valid, out_data, busy, done
   );
endinterface

// File: rtl/loadable_fibonacci_lfsr.sv
// Fibonacci LFSR with synchronous load and step enable; emitted bit is value[0]
// before the step. Load wins over step; an all-zero load becomes DEFAULT_SEED.
module loadable_fibonacci_lfsr #(
   parameter int              WIDTH        = 8,
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'h1D),
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             step,
   output logic             out_bit
);

   logic [WIDTH-1:0] value;
   logic             feedback;

   assign feedback = ^(value & TAPS);
   assign out_bit  = value[0];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         value <= DEFAULT_SEED;
      end else if (load) begin
         value <= (load_value == '0) ? DEFAULT_SEED : load_value;
      end else if (step) begin
         value <= (value >> 1) | (WIDTH'(feedback) << (WIDTH - 1));
      end
   end

endmodule

// File: rtl/prbs_word_sequencer.sv
// Emits word_count LFSR words, WORD_WIDTH cycles to build each, held on a
// valid/ready port until accepted; abort returns to IDLE without done.
module prbs_word_sequencer
   import prbs_pkg::*;
#(
   parameter int                    LFSR_WIDTH   = 8,
   parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = LFSR_WIDTH'(default_taps(LFSR_WIDTH)),
   parameter int                    WORD_WIDTH   = 8,
   parameter int                    COUNT_WIDTH  = 16,
   parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = LFSR_WIDTH'(1)
) (
   input  logic                  clock,
   input  logic                  resetn,
   prbs_word_sequencer_if.master bus
);

   localparam int              BIT_W    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 1);

   state_t                 state;
   state_t                 state_next;
   logic [BIT_W-1:0]       bit_index;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [WORD_WIDTH-1:0]  word;
   logic                   start_go;
   logic                   lfsr_step;
   logic                   lfsr_bit;
   logic                   handshake;

   assign start_go  = (state == IDLE) && bus.start && !bus.abort;
   assign lfsr_step = (state == GENERATE) && !bus.abort;
   assign handshake = (state == OUTPUT) && bus.out_ready;

   loadable_fibonacci_lfsr #(
      .WIDTH        (LFSR_WIDTH),
      .TAPS         (LFSR_TAPS),
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_lfsr (
      .clock      (clock),
      .resetn     (resetn),
      .load       (start_go),
      .load_value (bus.seed),
      .step       (lfsr_step),
      .out_bit    (lfsr_bit)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state_next = (bus.word_count == '0) ? FINISH : GENERATE;
               end
            end
            GENERATE: begin
               if (bit_index == LAST_BIT) begin
                  state_next = OUTPUT;
               end
            end
            OUTPUT: begin
               if (handshake) begin
                  state_next = (remaining == COUNT_WIDTH'(1)) ? FINISH : GENERATE;
               end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.out_valid = (state == OUTPUT);
      bus.busy      = (state != IDLE);
      bus.done      = (state == FINISH);
      bus.out_data  = word;
   end

   // Bits arrive LSB first, so shifting in at the MSB leaves the first bit at
   // bit 0 once a full word has been collected.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bit_index <= '0;
         remaining <= '0;
         word      <= '0;
      end else begin
         if (start_go) begin
            remaining <= bus.word_count;
            bit_index <= '0;
         end
         if (lfsr_step) begin
            word      <= (word >> 1) | (WORD_WIDTH'(lfsr_bit) << (WORD_WIDTH - 1));
            bit_index <= (bit_index == LAST_BIT) ? '0 : bit_index + 1'b1;
         end
         if (handshake) begin
            remaining <= remaining - 1'b1;
         end
      end
   end

endmodule
